// File: rtl/owt_tx_ctrl_mq.sv
// owt_tx_ctrl_mq: queued one-wire Manchester transmit controller.
// Frame: head, sync tail, cmd, data, crc8, end tail; abortable.
module owt_tx_ctrl_mq #(
  parameter int              AW         = 7,
  parameter int              DW         = 8,
  parameter int              ADCW       = 10,
  parameter logic [AW-1:0]   ADC_ADDR   = 7'h7F,
  parameter int              HEAD_BITS  = 8,
  parameter int              FIFO_DEPTH = 4,
  parameter int              HCW        = 8,
  parameter int              ABORT_SYMS = 8,
  parameter logic [7:0]      CRC_POLY   = 8'h07
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cmd_vld,
  output logic                          o_cmd_rdy,
  input  logic                          i_cmd_wr,
  input  logic [AW-1:0]                 i_cmd_addr,
  input  logic [ADCW-1:0]               i_cmd_data,
  input  logic [HCW-1:0]                i_half_cyc,
  input  logic                          i_abort,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic                          o_abort_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + ADCW;
  localparam int SW = 16;

  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] N_HEAD = SW'(2 * HEAD_BITS);
  localparam logic [SW-1:0] N_TAIL = SW'(4);
  localparam logic [SW-1:0] N_CMD  = SW'(2 * (AW + 1));
  localparam logic [SW-1:0] N_DAT  = SW'(2 * DW);
  localparam logic [SW-1:0] N_ADC  = SW'(2 * ADCW);
  localparam logic [SW-1:0] N_CRC  = SW'(16);
  localparam logic [SW-1:0] N_ABT  = SW'(ABORT_SYMS);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_STAIL, S_CMD,
    S_DATA, S_CRC, S_ETAIL, S_ABORT
  } state_t;

  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            push, pop;

  state_t          st_q, st_d, nxt;
  logic [SW-1:0]   sym_q, sym_d, nsym, bidx;
  logic [HCW-1:0]  cyc_q, cyc_d, hc_q, hc_last;
  logic [AW:0]     cmd_q, cmd_sh;
  logic [ADCW-1:0] dat_q, dat_al, dat_sh;
  logic [7:0]      crc_q, crc_d, crc_in, crc_sh;
  logic            tx_q, busy_q, fdone_q, adone_q;
  logic            tx_d, fdone_d, adone_d, fbit;
  logic            adv, last_cyc, last_sym, is_adc;

  assign o_cmd_rdy    = cnt_q < DEPTH;
  assign push         = i_cmd_vld && o_cmd_rdy;
  assign o_fifo_cnt   = cnt_q;
  assign o_tx         = tx_q;
  assign o_busy       = busy_q;
  assign o_frame_done = fdone_q;
  assign o_abort_done = adone_q;

  assign is_adc   = cmd_q[AW-1:0] == ADC_ADDR;
  assign hc_last  = hc_q - 1'b1;
  assign last_cyc = cyc_q == hc_last;
  assign last_sym = sym_q == nsym - 1'b1;

  // Queue storage: written on accept, not reset.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= {i_cmd_wr, i_cmd_addr, i_cmd_data};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Symbol count and successor of the current state.
  always_comb begin
    nsym = N_TAIL;
    nxt  = S_IDLE;
    case (st_q)
      S_HEAD:  begin nsym = N_HEAD; nxt = S_STAIL; end
      S_STAIL: begin nsym = N_TAIL; nxt = S_CMD;   end
      S_CMD:   begin nsym = N_CMD;  nxt = S_DATA;  end
      S_DATA:  begin
        nsym = is_adc ? N_ADC : N_DAT;
        nxt  = S_CRC;
      end
      S_CRC:   begin nsym = N_CRC;  nxt = S_ETAIL; end
      S_ETAIL: begin nsym = N_TAIL; nxt = S_IDLE;  end
      S_ABORT: begin nsym = N_ABT;  nxt = S_IDLE;  end
      default: begin nsym = N_TAIL; nxt = S_IDLE;  end
    endcase
  end

  // Next position: pop, abort, or advance by one cycle.
  always_comb begin
    st_d  = st_q;
    sym_d = sym_q;
    cyc_d = cyc_q;
    pop   = 1'b0;
    adv   = 1'b0;
    if (st_q == S_IDLE) begin
      if (cnt_q != '0) begin
        pop   = 1'b1;
        st_d  = S_HEAD;
        sym_d = '0;
        cyc_d = '0;
      end
    end else if (i_abort && st_q != S_ABORT) begin
      st_d  = S_ABORT;
      sym_d = '0;
      cyc_d = '0;
    end else if (last_cyc) begin
      adv   = 1'b1;
      cyc_d = '0;
      if (last_sym) begin
        st_d  = nxt;
        sym_d = '0;
      end else begin
        sym_d = sym_q + 1'b1;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // Line level of the symbol at the next position.
  always_comb begin
    bidx   = sym_d >> 1;
    cmd_sh = cmd_q << bidx;
    dat_al = is_adc ? dat_q : dat_q << (ADCW - DW);
    dat_sh = dat_al << bidx;
    crc_sh = crc_q << bidx;
    fbit   = 1'b0;
    tx_d   = 1'b0;
    case (st_d)
      S_HEAD:  tx_d = sym_d[0];
      S_STAIL: tx_d = ~sym_d[1];
      S_ETAIL: tx_d = ~sym_d[1];
      S_CMD:   begin fbit = cmd_sh[AW];      tx_d = fbit ^ sym_d[0]; end
      S_DATA:  begin fbit = dat_sh[ADCW-1];  tx_d = fbit ^ sym_d[0]; end
      S_CRC:   begin fbit = crc_sh[7];       tx_d = fbit ^ sym_d[0]; end
      default: tx_d = 1'b0;
    endcase
  end

  // CRC absorbs each cmd/data bit as its first symbol starts.
  always_comb begin
    crc_in = crc_q;
    crc_d  = crc_q;
    if (adv && (st_d == S_CMD || st_d == S_DATA) && !sym_d[0]) begin
      crc_in = (st_q == S_STAIL) ? 8'h00 : crc_q;
      crc_d  = {crc_in[6:0], 1'b0} ^ ((crc_in[7] ^ fbit) ? CRC_POLY : 8'h00);
    end
  end

  // Completion pulses land on the final cycle of the last symbol.
  always_comb begin
    fdone_d = (st_d == S_ETAIL) && (sym_d == N_TAIL - 1'b1)
              && (cyc_d == hc_last);
    adone_d = (st_d == S_ABORT) && (sym_d == N_ABT - 1'b1)
              && (cyc_d == hc_last);
  end

  // FSM state, latched entry and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q    <= S_IDLE;
      sym_q   <= '0;
      cyc_q   <= '0;
      hc_q    <= HCW'(1);
      cmd_q   <= '0;
      dat_q   <= '0;
      crc_q   <= '0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      adone_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      sym_q   <= sym_d;
      cyc_q   <= cyc_d;
      crc_q   <= crc_d;
      if (pop) begin
        {cmd_q, dat_q} <= mem_q[rptr_q];
        hc_q <= (i_half_cyc == '0) ? HCW'(1) : i_half_cyc;
      end
      tx_q    <= tx_d;
      busy_q  <= st_d != S_IDLE;
      fdone_q <= fdone_d;
      adone_q <= adone_d;
    end
  end

endmodule

// File: tb/tb_owt_tx_ctrl_mq.sv
// tb_owt_tx_ctrl_mq: scoreboard bench for the queued one-wire transmitter.
// Stimulus queues commands; a monitor decodes the line against a frame model.
`timescale 1ns/1ps
module tb_owt_tx_ctrl_mq;
  localparam int AW = 7, DW = 8, ADCW = 10, HEAD_BITS = 8;
  localparam int FIFO_DEPTH = 4, HCW = 8, ABORT_SYMS = 8;
  localparam logic [AW-1:0] ADC_ADDR = 7'h7F;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vld = 1'b0, wr = 1'b0, ab = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [ADCW-1:0] data = '0;
  logic [HCW-1:0] half = 8'd1;
  logic rdy, tx, busy, fdone, adone;
  logic [CW-1:0] cnt;

  owt_tx_ctrl_mq dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_vld(vld), .o_cmd_rdy(rdy),
    .i_cmd_wr(wr), .i_cmd_addr(addr), .i_cmd_data(data),
    .i_half_cyc(half), .i_abort(ab), .o_tx(tx), .o_busy(busy),
    .o_frame_done(fdone), .o_abort_done(adone), .o_fifo_cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic wr;
    logic [AW-1:0] addr;
    logic [ADCW-1:0] data;
  } cmd_t;

  cmd_t sb[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference frame: list of line symbols, one entry per symbol.
  bit ref_syms[$];
  logic [7:0] ref_crc;

  function automatic void build_ref(input cmd_t c);
    bit bits[$];
    logic [7:0] crc;
    int dl;
    crc = 8'h00;
    ref_syms = {};
    for (int i = 0; i < HEAD_BITS; i++) begin
      ref_syms.push_back(1'b0);
      ref_syms.push_back(1'b1);
    end
    ref_syms.push_back(1'b1); ref_syms.push_back(1'b1);
    ref_syms.push_back(1'b0); ref_syms.push_back(1'b0);
    bits.push_back(c.wr);
    for (int i = AW - 1; i >= 0; i--) bits.push_back(c.addr[i]);
    dl = (c.addr == ADC_ADDR) ? ADCW : DW;
    for (int i = dl - 1; i >= 0; i--) bits.push_back(c.data[i]);
    foreach (bits[i]) begin
      bit fb;
      fb = crc[7] ^ bits[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    ref_crc = crc;
    for (int i = 7; i >= 0; i--) bits.push_back(crc[i]);
    foreach (bits[i]) begin
      ref_syms.push_back(bits[i]);
      ref_syms.push_back(!bits[i]);
    end
    ref_syms.push_back(1'b1); ref_syms.push_back(1'b1);
    ref_syms.push_back(1'b0); ref_syms.push_back(1'b0);
  endfunction

  // Monitor state
  int cyc_k = 0, done_cnt = 0, abort_cnt = 0;
  bit cap[$];
  int hc_cur = 1;
  logic prev_busy = 1'b0;
  logic [HCW-1:0] prev_hc = '0;
  bit aborting = 0, abort_nz = 0, gap_pending = 0, ok;
  int abort_k = 0, done_k = 0;
  logic [7:0] last_cmd = '0, last_crc = '0;
  int last_nsym = 0, last_cyc = 0;
  int len_log[$];
  cmd_t mc;

  // Decode the line and compare each finished frame with the model.
  always @(negedge clk) begin
    cyc_k++;
    if (rst) begin
      prev_busy = 1'b0;
      cap = {};
      aborting = 0;
      gap_pending = 0;
    end else begin
      if (busy && !prev_busy) begin
        cap = {};
        hc_cur = (prev_hc == '0) ? 1 : int'(prev_hc);
        if (gap_pending) chk("gap", cyc_k - done_k, 2);
        gap_pending = 0;
      end
      if (busy) cap.push_back(tx);
      if (aborting && cyc_k > abort_k && tx) abort_nz = 1;
      if (busy && ab && !aborting) begin
        aborting = 1;
        abort_k = cyc_k;
        abort_nz = 0;
      end
      if (adone) begin
        abort_cnt++;
        chk("abort_len", aborting ? cyc_k - abort_k : -1,
            ABORT_SYMS * hc_cur);
        chk("abort_line", abort_nz, 0);
        chk("abort_sb", sb.size() > 0, 1);
        if (sb.size() > 0) void'(sb.pop_front());
        aborting = 0;
        done_k = cyc_k;
        gap_pending = sb.size() > 0;
      end
      if (fdone) begin
        done_cnt++;
        chk("frame_sb", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mc = sb.pop_front();
          build_ref(mc);
          chk("frame_len", cap.size(), ref_syms.size() * hc_cur);
          ok = cap.size() == ref_syms.size() * hc_cur;
          if (ok)
            foreach (cap[i]) if (cap[i] != ref_syms[i / hc_cur]) ok = 0;
          chk("frame_wave", ok, 1);
        end
        last_cyc = cap.size();
        last_nsym = cap.size() / hc_cur;
        len_log.push_back(last_cyc);
        if (last_nsym >= 56) begin
          for (int b = 0; b < 8; b++) begin
            last_cmd[7-b] = cap[(20 + 2*b) * hc_cur];
            last_crc[7-b] = cap[(last_nsym - 20 + 2*b) * hc_cur];
          end
        end
        done_k = cyc_k;
        gap_pending = sb.size() > 0;
      end
      prev_busy = busy;
    end
    prev_hc = half;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a,
                      input logic [ADCW-1:0] d);
    cmd_t c;
    bit acc;
    acc = 0;
    c.wr = w; c.addr = a; c.data = d;
    vld = 1'b1; wr = w; addr = a; data = d;
    for (int n = 0; n < 5000 && !acc; n++) begin
      @(negedge clk);
      acc = rdy;
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    if (acc) sb.push_back(c);
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 1000) begin tick(); n++; end
    chk("busy_start", busy, 1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() > 0 || busy || cnt != '0) && n < 20000) begin
      tick();
      n++;
    end
    chk({nm, "_drain"}, n < 20000, 1);
    tick();
  endtask

  int d0, a0, n0;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    #1;
    chk("rst_tx", tx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_adone", adone, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_rdy", rdy, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Directed write, HC=2
    half = 8'd2;
    d0 = done_cnt;
    push(1'b1, 7'h15, 10'h0A5);
    drain("wr");
    chk("wr_cmd", last_cmd, 8'h95);
    chk("wr_crc", last_crc, 8'hD2);
    chk("wr_nsym", last_nsym, 72);
    chk("wr_busy_cyc", last_cyc, 144);
    chk("wr_done_cnt", done_cnt - d0, 1);

    // ADC request, HC=1
    half = 8'd1;
    push(1'b0, ADC_ADDR, 10'h2C3);
    drain("adc");
    chk("adc_nsym", last_nsym, 76);
    chk("adc_crc", last_crc, ref_crc);

    // Queue fill while a frame is on the line
    half = 8'd1;
    d0 = done_cnt;
    push(1'b1, 7'h01, 10'h011);
    tick();
    for (int i = 0; i < 4; i++)
      push(i[0], AW'(7'h20 + i), ADCW'(10'h3C + i));
    chk("q_full_rdy", rdy, 0);
    chk("q_full_cnt", cnt, 4);
    push(1'b0, 7'h33, 10'h155);
    chk("q_5th_cnt", cnt, 4);
    drain("queue");
    chk("q_done_cnt", done_cnt - d0, 6);

    // Abort during DATA bit 3, HC=2
    half = 8'd2;
    d0 = done_cnt;
    a0 = abort_cnt;
    push(1'b1, 7'h0C, 10'h05A);
    wait_busy();
    push(1'b0, 7'h44, 10'h0C3);
    repeat (42 * 2 - 1) tick();
    ab = 1'b1;
    tick();
    ab = 1'b0;
    drain("abort");
    chk("ab_abort_cnt", abort_cnt - a0, 1);
    chk("ab_done_cnt", done_cnt - d0, 1);

    // HC=0 acts as 1; mid-frame HC change only at next pop
    half = 8'd0;
    push(1'b1, 7'h55, 10'h0AA);
    drain("hc0");
    chk("hc0_cyc", last_cyc, 72);
    half = 8'd3;
    push(1'b0, 7'h12, 10'h034);
    wait_busy();
    half = 8'd1;
    push(1'b1, 7'h7F, 10'h3FF);
    drain("hcchg");
    n0 = len_log.size();
    chk("hcchg_first", n0 >= 2 ? len_log[n0-2] : -1, 72 * 3);
    chk("hcchg_second", n0 >= 1 ? len_log[n0-1] : -1, 76);

    // Randomised commands
    for (int i = 0; i < 25; i++) begin
      half = HCW'($urandom_range(0, 3));
      push(1'($urandom),
           ($urandom_range(0, 3) == 0) ? ADC_ADDR : AW'($urandom),
           ADCW'($urandom));
      repeat ($urandom_range(0, 40)) tick();
    end
    drain("rand");

    // Asynchronous reset in the CRC field with commands queued
    half = 8'd1;
    push(1'b1, 7'h2A, 10'h0F0);
    tick();
    push(1'b0, 7'h2B, 10'h00F);
    push(1'b1, 7'h2C, 10'h0FF);
    repeat (52) tick();
    #2 rst = 1'b1;
    #1;
    sb.delete();
    d0 = done_cnt;
    chk("mrst_tx", tx, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_rdy", rdy, 1);
    chk("mrst_fdone", fdone, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) tick();
    chk("mrst_no_done", done_cnt - d0, 0);
    chk("mrst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
